// File: rtl/array_stream_packer.sv
// Packs a stream of elements into one flat frame vector.
// Valid/ready in, valid/ready out; frame ends at N elements or in_last.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_data/in_valid/in_last   element stream, in_ready back-pressure
//   flush                      synchronous discard of partial/held frame
//   out/out_valid/out_ready    packed frame handshake
//   out_short                  frame ended by in_last before N elements
//   fill_count                 elements accepted into current frame
module array_stream_packer #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [BIT_WIDTH-1:0]                 in_data,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    output logic                                 in_ready,
    input  logic                                 flush,
    output logic [ROWS*COLS*BIT_WIDTH-1:0]       out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_short,
    output logic [$clog2(ROWS*COLS+1)-1:0]       fill_count
);

    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;

    logic is_final;
    assign is_final = (fill_count == CW'(N - 1));

    // in_ready and out_valid are registered copies of the next state,
    // so in_ready stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            out        <= '0;
            out_valid  <= 1'b0;
            out_short  <= 1'b0;
            fill_count <= '0;
            in_ready   <= 1'b0;
        end else if (flush) begin
            state      <= FILL;
            out        <= '0;
            out_valid  <= 1'b0;
            out_short  <= 1'b0;
            fill_count <= '0;
            in_ready   <= 1'b1;
        end else begin
            unique case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < N; i++) begin
                            if (fill_count == CW'(i))
                                out[i*BIT_WIDTH +: BIT_WIDTH] <= in_data;
                        end
                        fill_count <= fill_count + 1'b1;
                        if (is_final || in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_short <= !is_final;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state      <= FILL;
                        out        <= '0;
                        out_valid  <= 1'b0;
                        out_short  <= 1'b0;
                        fill_count <= '0;
                        in_ready   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
